sha256_msg_ctrl: RTL and testbench

Multi-block message sequencer for the `SHA256top` compression core. It accepts pre-padded 512-bit blocks over a valid/ready handshake and drives the core's `start_in`/`sha256_done` handshake once per block. It chains each block's 256-bit result into the next block's initial hash values and presents the final digest with a valid/ack handshake. It sits between the message source (host bus or DMA) and the single `SHA256top` instance.

---
 rtl/sha256_msg_ctrl.sv | 151 +++++++++++++++
 tb/tb_sha256_msg_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_ctrl.sv
// Multi-block message sequencer for a single SHA256top compression core:
// accepts padded blocks, chains intermediate hashes, presents the final digest.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for the first block of a message; chain holds H0
// RUN   | core_start held high until the core reports done
// DROP  | core_start low, waiting for core_done to fall
// NEXT  | waiting for the next block; chain holds the intermediate hash
// OUT   | digest presented, waiting for digest_ack
// DRAIN | message discarded, waiting for core_done to fall
module sha256_msg_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_last,
  input  logic             abort,
  output logic [255:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ack,
  output logic             busy,
  output logic [CNT_W-1:0] block_count,
  output logic             chain_zero_err,
  output logic             core_start,
  output logic [511:0]     core_w,
  output logic [255:0]     core_iv,
  input  logic [255:0]     core_result,
  input  logic             core_done
);

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DROP  = 3'd2,
    S_NEXT  = 3'd3,
    S_OUT   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q;
  logic [511:0]       blk_q;
  logic               last_q;
  logic [255:0]       chain_q;
  logic [255:0]       digest_q;
  logic [CNT_W-1:0]   count_q;
  logic               zero_err_q;

  logic               accept_ok;
  logic               handshake;
  logic               capture;
  logic               reload;
  logic               load_digest;
  logic               result_has_zero;

  // armed_q keeps blk_ready low while reset is held; ready is also withheld
  // while a stale core_done is high so core_start never rises against it.
  assign accept_ok = armed_q && !core_done &&
                     ((state_q == S_IDLE) || ((state_q == S_NEXT) && !abort));
  assign handshake = blk_valid && accept_ok;

  assign capture     = (state_q == S_RUN) && !abort && core_done;
  assign load_digest = (state_q == S_DROP) && !abort && !core_done && last_q;
  assign reload      = ((state_q == S_OUT) && digest_ack) ||
                       ((state_q == S_DRAIN) && !core_done);

  always_comb begin
    result_has_zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (core_result[32*i +: 32] == 32'd0) result_has_zero = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (handshake) state_d = S_RUN;
      S_RUN: begin
        if (abort)          state_d = S_DRAIN;
        else if (core_done) state_d = S_DROP;
      end
      S_DROP: begin
        if (abort)           state_d = S_DRAIN;
        else if (!core_done) state_d = last_q ? S_OUT : S_NEXT;
      end
      S_NEXT: begin
        if (abort)          state_d = S_DRAIN;
        else if (handshake) state_d = S_RUN;
      end
      S_OUT:   if (digest_ack) state_d = S_IDLE;
      S_DRAIN: if (!core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q      <= '0;
      last_q     <= 1'b0;
      chain_q    <= H0;
      digest_q   <= '0;
      count_q    <= '0;
      zero_err_q <= 1'b0;
    end else begin
      if (handshake) begin
        blk_q  <= blk_data;
        last_q <= blk_last;
      end
      if (handshake && (state_q == S_IDLE)) begin
        count_q    <= '0;
        zero_err_q <= 1'b0;
      end
      if (capture) begin
        chain_q <= core_result;
        if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
        // the core would silently swap a zero chaining word for its default IV
        if (!last_q && result_has_zero) zero_err_q <= 1'b1;
      end
      if (reload)      chain_q  <= H0;
      if (load_digest) digest_q <= chain_q;
    end
  end

  assign blk_ready      = accept_ok;
  assign busy           = (state_q != S_IDLE);
  assign core_start     = (state_q == S_RUN);
  assign digest_valid   = (state_q == S_OUT);
  assign digest         = digest_q;
  assign block_count    = count_q;
  assign chain_zero_err = zero_err_q;
  assign core_w         = blk_q;
  assign core_iv        = chain_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: behavioural SHA-256 core model plus a reference
// hash computed from whole messages, directed and randomized messages.
`timescale 1ns/1ps

module tb_sha256_msg_ctrl;
  localparam int CNT_W = 16;
  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             blk_valid = 1'b0, blk_last = 1'b0, abort = 1'b0, digest_ack = 1'b0;
  logic [511:0]     blk_data = '0;
  logic             blk_ready, digest_valid, busy, chain_zero_err, core_start;
  logic [255:0]     digest, core_iv;
  logic [511:0]     core_w;
  logic [CNT_W-1:0] block_count;
  logic [255:0]     core_result = '0;
  logic             core_done = 1'b0;

  sha256_msg_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last), .abort(abort), .digest(digest),
    .digest_valid(digest_valid), .digest_ack(digest_ack), .busy(busy),
    .block_count(block_count), .chain_zero_err(chain_zero_err), .core_start(core_start),
    .core_w(core_w), .core_iv(core_iv), .core_result(core_result), .core_done(core_done));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = iv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {iv[255:224] + a, iv[223:192] + b, iv[191:160] + c, iv[159:128] + d,
            iv[127:96] + e, iv[95:64] + f, iv[63:32] + g, iv[31:0] + h};
  endfunction

  // the real core replaces each zero IV word by its default value
  function automatic logic [255:0] core_eff_iv(input logic [255:0] iv);
    logic [255:0] r = iv;
    for (int i = 0; i < 8; i++) if (iv[32*i +: 32] == 32'd0) r[32*i +: 32] = H0[32*i +: 32];
    return r;
  endfunction

  function automatic bit any_zero_word(input logic [255:0] v);
    for (int i = 0; i < 8; i++) if (v[32*i +: 32] == 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  // behavioural core: done after core_lat cycles of start, falls core_fall cycles after start drops
  int core_lat = 3, core_fall = 0, lat_cnt = 0, fall_cnt = 0;
  always @(posedge clk) begin
    if (core_start) begin
      fall_cnt <= 0;
      if (!core_done) begin
        if (lat_cnt >= core_lat) begin
          core_done   <= 1'b1;
          core_result <= compress(core_eff_iv(core_iv), core_w);
          lat_cnt     <= 0;
        end else lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
      if (core_done) begin
        if (fall_cnt >= core_fall) begin
          core_done <= 1'b0;
          fall_cnt  <= 0;
        end else fall_cnt <= fall_cnt + 1;
      end
    end
  end

  // protocol monitor: start periods, accepted blocks, stability violations
  int start_cnt = 0, acc_cnt = 0, viol = 0;
  logic prev_start = 1'b0, prev_dv = 1'b0;
  logic [511:0] prev_w = '0;
  logic [255:0] prev_iv = '0, prev_dig = '0;
  always @(posedge clk) begin
    if (core_start && !prev_start) begin
      start_cnt++;
      if (core_done) viol++;
    end
    if (core_start && prev_start && (core_w !== prev_w || core_iv !== prev_iv)) viol++;
    if (digest_valid && prev_dv && digest !== prev_dig) viol++;
    if (blk_valid && blk_ready) acc_cnt++;
    prev_start = core_start; prev_dv = digest_valid;
    prev_w = core_w; prev_iv = core_iv; prev_dig = digest;
  end

  logic [511:0] msg [$];
  logic [255:0] obs_digest;

  task automatic send_blk(input logic [511:0] b, input logic l, output bit ok);
    int t = 0;
    @(negedge clk);
    blk_valid = 1'b1; blk_data = b; blk_last = l;
    #1;
    while (!blk_ready && t < 2000) begin @(negedge clk); #1; t++; end
    ok = blk_ready;
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0; blk_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    #1;
    while (busy && t < 2000) begin @(negedge clk); #1; t++; end
    chk({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic run_msg(input string tag, input int ack_wait);
    logic [255:0] h = H0, d0;
    bit zerr = 1'b0, ok;
    int n = msg.size(), s0 = start_cnt, v0 = viol, a0, t = 0;
    for (int i = 0; i < n; i++) begin
      send_blk(msg[i], (i == n - 1), ok);
      chk({tag, "_accept"}, ok, 1'b1);
      #1;
      chk({tag, "_start"}, core_start, 1'b1);
      chk({tag, "_iv"}, core_iv, h);
      h = compress(core_eff_iv(h), msg[i]);
      if (i < n - 1 && any_zero_word(h)) zerr = 1'b1;
    end
    while (!digest_valid && t < 2000) begin @(negedge clk); #1; t++; end
    chk({tag, "_dv_timeout"}, digest_valid, 1'b1);
    obs_digest = digest;
    chk({tag, "_digest"}, digest, h);
    chk({tag, "_count"}, block_count, n);
    chk({tag, "_zero_err"}, chain_zero_err, zerr);
    d0 = digest; a0 = acc_cnt;
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      blk_valid = 1'b1; blk_data = {16{$urandom}};
      #1;
      chk({tag, "_bp_ready"}, blk_ready, 1'b0);
      chk({tag, "_bp_dv"}, digest_valid, 1'b1);
      chk({tag, "_bp_digest"}, digest, d0);
    end
    @(negedge clk);
    blk_valid = 1'b0; digest_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    digest_ack = 1'b0;
    #1;
    chk({tag, "_bp_accepted"}, acc_cnt - a0, 0);
    chk({tag, "_ack_dv"}, digest_valid, 1'b0);
    chk({tag, "_ack_ready"}, blk_ready, 1'b1);
    chk({tag, "_ack_busy"}, busy, 1'b0);
    chk({tag, "_start_periods"}, start_cnt - s0, n);
    chk({tag, "_protocol"}, viol - v0, 0);
  endtask

  function automatic logic [511:0] blk2(input logic [31:0] w0, input logic [31:0] w15);
    logic [511:0] b = '0;
    b[511:480] = w0; b[31:0] = w15;
    return b;
  endfunction

  logic [511:0] abc_blk, two_b1, two_b2;
  bit ok;
  int a0, t;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    abc_blk = blk2(32'h61626380, 32'h00000018);
    two_b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
              32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
              32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2 = blk2(32'h0, 32'h000001c0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", blk_ready, 1'b0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_dv", digest_valid, 1'b0);
    chk("rst_count", block_count, 0);
    chk("rst_iv", core_iv, H0);
    chk("rst_digest", digest, 0);
    chk("rst_w", core_w[255:0] | core_w[511:256], 0);
    @(negedge clk);
    reset = 1'b1;

    core_lat = 3; core_fall = 0;
    msg = '{abc_blk};
    run_msg("abc", 0);
    chk("abc_known", obs_digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    core_lat = 5; core_fall = 2;
    msg = '{two_b1, two_b2};
    run_msg("two", 0);
    chk("two_known", obs_digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    core_lat = 1; core_fall = 1;
    msg = '{blk2(32'h80000000, 32'h0)};
    run_msg("empty", 0);
    chk("empty_known", obs_digest, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    msg = '{blk2(32'h61800000, 32'h00000008)};
    run_msg("a_bp", 10);
    chk("a_known", obs_digest, 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb);

    // abort while block 1 is in RUN
    core_lat = 4; core_fall = 2;
    send_blk(two_b1, 1'b0, ok);
    chk("abrun_accept", ok, 1'b1);
    #1;
    chk("abrun_start", core_start, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abrun_start_low", core_start, 1'b0);
    chk("abrun_busy", busy, 1'b1);
    chk("abrun_ready", blk_ready, 1'b0);
    wait_idle("abrun");
    chk("abrun_iv", core_iv, H0);
    chk("abrun_done_low", core_done, 1'b0);
    msg = '{abc_blk};
    run_msg("abc_after_abort", 0);

    // abort in NEXT racing a block handshake
    core_lat = 2; core_fall = 1;
    send_blk(two_b1, 1'b0, ok);
    chk("abnext_accept", ok, 1'b1);
    t = 0;
    #1;
    while (!blk_ready && t < 2000) begin @(negedge clk); #1; t++; end
    chk("abnext_ready_timeout", blk_ready, 1'b1);
    blk_valid = 1'b1; blk_data = two_b2; blk_last = 1'b1; abort = 1'b1;
    a0 = acc_cnt;
    #1;
    chk("abnext_ready_blocked", blk_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0; blk_last = 1'b0; abort = 1'b0;
    #1;
    chk("abnext_accepted", acc_cnt - a0, 0);
    chk("abnext_busy", busy, 1'b1);
    chk("abnext_start", core_start, 1'b0);
    chk("abnext_count", block_count, 1);
    wait_idle("abnext");
    chk("abnext_iv", core_iv, H0);

    // asynchronous reset mid-RUN
    core_lat = 8; core_fall = 0;
    send_blk(abc_blk, 1'b1, ok);
    chk("arst_accept", ok, 1'b1);
    #3;
    chk("arst_running", core_start, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_start", core_start, 1'b0);
    chk("arst_ready", blk_ready, 1'b0);
    chk("arst_dv", digest_valid, 1'b0);
    chk("arst_count", block_count, 0);
    chk("arst_iv", core_iv, H0);
    chk("arst_w", core_w[255:0] | core_w[511:256], 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    core_lat = 3;
    msg = '{abc_blk};
    run_msg("abc_after_reset", 0);
    chk("abc_after_reset_known", obs_digest,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    for (int m = 0; m < 5; m++) begin
      int nb = $urandom_range(1, 3);
      core_lat = $urandom_range(1, 6);
      core_fall = $urandom_range(0, 3);
      msg.delete();
      for (int i = 0; i < nb; i++) msg.push_back({16{$urandom}} ^ {$urandom, $urandom, $urandom, $urandom,
        $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
        $urandom, $urandom, $urandom, $urandom});
      run_msg($sformatf("rand%0d", m), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
